// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// response error codes and the request classifier.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW,
    WRITE,
    ERR,
    RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } lsu_err_e;

  // Priority: illegal encoding, then alignment, then address range.
  function automatic lsu_err_e lsu_classify(input logic        we,
                                            input logic [2:0]  funct3,
                                            input logic [31:0] addr,
                                            input logic [31:0] last_word);
    lsu_err_e err;
    err = ERR_NONE;
    if ((funct3 inside {3'b011, 3'b110, 3'b111}) || (we && funct3[2])) begin
      err = ERR_ILLEGAL;
    end else if (((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                 (funct3 == F3_W && addr[1:0] != 2'b00)) begin
      err = ERR_MISALIGN;
    end else if ({addr[31:2], 2'b00} > last_word) begin
      err = ERR_RANGE;
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering between a memory word and sub-word data: extracts and extends
// load lanes, and merges store lanes into a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rd_word_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_word_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rd_word_i[{offset_i, 3'b000} +: 8];
  assign half_lane = offset_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

  // funct3[2] selects zero extension; funct3[1:0] selects the access size.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    load_data_o  = rd_word_i;
    merge_word_o = rd_word_i;
    case (funct3_i[1:0])
      2'b00: begin
        load_data_o = funct3_i[2] ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        merge_word_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      2'b01: begin
        load_data_o = funct3_i[2] ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        merge_word_o[{offset_i[1], 4'b0000} +: 16] = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-wide memory without byte
// enables; sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  lsu_state_e  state_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic [15:0] wdata_q;
  lsu_err_e    err_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  lsu_err_e    resp_err_q;
  logic        mem_we_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_data_in_q;

  lsu_err_e    req_err_d;
  logic [31:0] load_data;
  logic [31:0] merge_word;

  assign req_err_d = lsu_classify(req_we, req_funct3, req_addr, LAST_WORD);

  lsu_align u_align (
    .funct3_i    (funct3_q),
    .offset_i    (offset_q),
    .rd_word_i   (mem_data_out),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merge_word_o(merge_word)
  );

  // mem_data_in_q doubles as the merge register: RMW parks the merged word
  // there so WRITE simply presents it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: every register, including the bus and response holds, is reset so
      // mem_we drops asynchronously and no stale data is visible after reset.
      state_q       <= IDLE;
      funct3_q      <= 3'b000;
      offset_q      <= 2'b00;
      wdata_q       <= 16'h0;
      err_q         <= ERR_NONE;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      resp_err_q    <= ERR_NONE;
      mem_we_q      <= 1'b0;
      mem_address_q <= 32'h0;
      mem_data_in_q <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      resp_valid_q <= 1'b0;
      mem_we_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            offset_q <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            err_q    <= req_err_d;
            if (req_err_d != ERR_NONE) begin
              state_q <= ERR;
            end else begin
              mem_address_q <= {req_addr[31:2], 2'b00};
              if (!req_we) begin
                state_q <= LOAD;
              end else if (req_funct3 == F3_W) begin
                state_q       <= WRITE;
                mem_we_q      <= 1'b1;
                mem_data_in_q <= req_wdata;
              end else begin
                state_q <= RMW;
              end
            end
          end
        end
        LOAD: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_data;
          resp_err_q   <= ERR_NONE;
        end
        RMW: begin
          state_q       <= WRITE;
          mem_we_q      <= 1'b1;
          mem_data_in_q <= merge_word;
        end
        WRITE: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'h0;
          resp_err_q   <= ERR_NONE;
        end
        ERR: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'h0;
          resp_err_q   <= err_q;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_we      = mem_we_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array reference model checked every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_load_store_unit;

  localparam int MEM_BYTES = 128;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_we      (mem_we),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] preload_word(input int i);
    if (i == 4) return 32'h8070F0FF;
    if (i == 8) return 32'hCAFEBABE;
    return {4{8'(i)}};
  endfunction

  // Attached memory device: word array, combinational read, write on rising edge.
  logic [31:0] dev_mem [MEM_BYTES/4];
  logic        dev_init = 1'b0;
  always @(posedge clock) begin
    if (!dev_init) begin
      for (int i = 0; i < MEM_BYTES/4; i++) dev_mem[i] <= preload_word(i);
      dev_init <= 1'b1;
    end else if (mem_we && mem_address < 32'(MEM_BYTES)) begin
      dev_mem[mem_address[6:2]] <= mem_data_in;
    end
  end
  assign mem_data_out = (mem_address < 32'(MEM_BYTES)) ? dev_mem[mem_address[6:2]] : 32'h0;

  // Reference model state: byte-addressed memory and the single pending transaction.
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        model_init = 1'b0;
  logic        resp_pend = 1'b0, wr_pend = 1'b0, touch_e = 1'b0;
  int          resp_cyc_e, wr_cyc_e;
  logic [31:0] rdata_e, addr_e, wr_data_e;
  logic [1:0]  err_e;
  // Observations of the DUT used by the directed literal checks.
  int          resp_count = 0, write_count = 0;
  int          acc_cyc = 0, last_resp_cyc = 0, prev_resp_cyc = 0, last_write_cyc = 0;
  logic [31:0] last_rdata = 0, prev_rdata = 0, last_write_data = 0;
  logic [1:0]  last_err = 0;

  task automatic model_accept(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata);
    int size;
    int base;
    logic [31:0] v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    resp_pend  = 1'b1;
    resp_cyc_e = cyc + 2;
    rdata_e    = 32'h0;
    touch_e    = 1'b0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3 >= 3'd4)) err_e = 2'b11;
    else if (addr % size != 0)                                         err_e = 2'b01;
    else if ((addr & ~32'h3) > 32'(MEM_BYTES - 4))                     err_e = 2'b10;
    else                                                               err_e = 2'b00;
    if (err_e == 2'b00) begin
      touch_e = 1'b1;
      addr_e  = addr & ~32'h3;
      base    = int'(addr_e);
      if (!we) begin
        v = 32'h0;
        for (int k = 0; k < size; k++) v |= 32'(ref_mem[int'(addr) + k]) << (8 * k);
        if (!f3[2] && size < 4 && v[8*size-1]) v |= 32'hFFFFFFFF << (8 * size);
        rdata_e = v;
      end else begin
        v = 32'h0;
        for (int k = 0; k < 4; k++) begin
          if (base + k >= int'(addr) && base + k < int'(addr) + size)
            v |= 32'(wdata[8*(base+k-int'(addr)) +: 8]) << (8 * k);
          else
            v |= 32'(ref_mem[base + k]) << (8 * k);
        end
        wr_pend    = 1'b1;
        wr_data_e  = v;
        wr_cyc_e   = cyc + ((size == 4) ? 1 : 2);
        resp_cyc_e = cyc + ((size == 4) ? 2 : 3);
      end
    end
  endtask

  // Compare process: mid-cycle, every cycle out of reset.
  initial begin
    logic ready_e, we_e, rv_e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        resp_pend = 1'b0;
        wr_pend   = 1'b0;
        if (!model_init) begin
          for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = preload_word(i / 4)[8*(i%4) +: 8];
          model_init = 1'b1;
        end
      end else begin
        if (wr_pend && cyc == wr_cyc_e + 1) begin
          for (int k = 0; k < 4; k++) ref_mem[int'(addr_e) + k] = wr_data_e[8*k +: 8];
          wr_pend = 1'b0;
        end
        ready_e = !resp_pend;
        check("req_ready", 32'(req_ready), 32'(ready_e));
        we_e = wr_pend && cyc == wr_cyc_e;
        check("mem_we", 32'(mem_we), 32'(we_e));
        if (mem_we) begin
          write_count++;
          last_write_cyc  = cyc;
          last_write_data = mem_data_in;
        end
        if (we_e) check("mem_data_in", mem_data_in, wr_data_e);
        if (resp_pend && touch_e) check("mem_address", mem_address, addr_e);
        rv_e = resp_pend && cyc == resp_cyc_e;
        check("resp_valid", 32'(resp_valid), 32'(rv_e));
        if (resp_valid) begin
          resp_count++;
          prev_resp_cyc = last_resp_cyc;
          prev_rdata    = last_rdata;
          last_resp_cyc = cyc;
          last_rdata    = resp_rdata;
          last_err      = resp_err;
        end
        if (rv_e) begin
          check("resp_rdata", resp_rdata, rdata_e);
          check("resp_err", 32'(resp_err), 32'(err_e));
          resp_pend = 1'b0;
        end
        if (req_valid && ready_e) begin
          model_accept(req_we, req_funct3, req_addr, req_wdata);
          acc_cyc = cyc;
        end
      end
    end
  end

  // One request with hand-computed result; wlat 0 means no memory write expected.
  task automatic run_vec(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                         input int lat, input int wlat, input logic [31:0] wword);
    int start_resp, start_wr;
    start_resp = resp_count;
    start_wr   = write_count;
    @(posedge clock); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clock); #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF;
    req_wdata = $urandom;
    for (int i = 0; i < 12 && resp_count == start_resp; i++) @(posedge clock);
    check({name, " resp count"}, 32'(resp_count), 32'(start_resp + 1));
    if (resp_count != start_resp) begin
      check({name, " rdata"}, last_rdata, exp_rdata);
      check({name, " err"}, 32'(last_err), 32'(exp_err));
      check({name, " latency"}, 32'(last_resp_cyc - acc_cyc), 32'(lat));
    end
    check({name, " writes"}, 32'(write_count - start_wr), (wlat != 0) ? 32'd1 : 32'd0);
    if (wlat != 0 && write_count != start_wr) begin
      check({name, " write cycle"}, 32'(last_write_cyc - acc_cyc), 32'(wlat));
      check({name, " write word"}, last_write_data, wword);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " resp_valid"},  32'(resp_valid), 32'd0);
    check({name, " req_ready"},   32'(req_ready), 32'd1);
    check({name, " mem_we"},      32'(mem_we), 32'd0);
    check({name, " mem_address"}, mem_address, 32'h0);
    check({name, " mem_data_in"}, mem_data_in, 32'h0);
    check({name, " resp_rdata"},  resp_rdata, 32'h0);
    check({name, " resp_err"},    32'(resp_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_first;
    int start_resp;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clock);
    #1 check_idle_outputs("reset");
    @(negedge clock); #2 reset = 1'b1;

    run_vec("LB 0x10",  1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFFF, 2'b00, 2, 0, 32'h0);
    run_vec("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 2'b00, 2, 0, 32'h0);
    run_vec("LH 0x12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8070, 2'b00, 2, 0, 32'h0);
    run_vec("LHU 0x10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000F0FF, 2'b00, 2, 0, 32'h0);
    run_vec("SB 0x11",  1'b1, 3'b000, 32'h11, 32'h123456AB, 32'h0, 2'b00, 3, 2, 32'h8070ABFF);
    run_vec("LW 0x10",  1'b0, 3'b010, 32'h10, 32'h0, 32'h8070ABFF, 2'b00, 2, 0, 32'h0);
    run_vec("SW 0x14",  1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 32'h0, 2'b00, 2, 1, 32'hDEADBEEF);
    run_vec("LW 0x14",  1'b0, 3'b010, 32'h14, 32'h0, 32'hDEADBEEF, 2'b00, 2, 0, 32'h0);
    run_vec("LHU 0x16", 1'b0, 3'b101, 32'h16, 32'h0, 32'h0000DEAD, 2'b00, 2, 0, 32'h0);
    run_vec("LB 0x14",  1'b0, 3'b000, 32'h14, 32'h0, 32'hFFFFFFEF, 2'b00, 2, 0, 32'h0);
    run_vec("SH 0x16",  1'b1, 3'b001, 32'h16, 32'hFFFF1234, 32'h0, 2'b00, 3, 2, 32'h1234BEEF);
    run_vec("LH 0x16",  1'b0, 3'b001, 32'h16, 32'h0, 32'h00001234, 2'b00, 2, 0, 32'h0);
    run_vec("LW 0x7C",  1'b0, 3'b010, 32'h7C, 32'h0, 32'h1F1F1F1F, 2'b00, 2, 0, 32'h0);
    run_vec("LW 0x12",  1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 2'b01, 2, 0, 32'h0);
    run_vec("SH 0x13",  1'b1, 3'b001, 32'h13, 32'h5555, 32'h0, 2'b01, 2, 0, 32'h0);
    run_vec("LW 0x80",  1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 2'b10, 2, 0, 32'h0);
    run_vec("LW 0x81",  1'b0, 3'b010, 32'h81, 32'h0, 32'h0, 2'b01, 2, 0, 32'h0);
    run_vec("F3 011",   1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 2'b11, 2, 0, 32'h0);
    run_vec("SB f3 100", 1'b1, 3'b100, 32'h10, 32'hAA, 32'h0, 2'b11, 2, 0, 32'h0);
    run_vec("SW f3 111", 1'b1, 3'b111, 32'h13, 32'h0, 32'h0, 2'b11, 2, 0, 32'h0);

    // Reset during the WRITE cycle of SH 0x20.
    @(posedge clock); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h20;
    req_wdata = 32'h00001111;
    @(posedge clock); #1 req_valid = 1'b0;
    @(posedge clock); #1 check("rst write cycle mem_we", 32'(mem_we), 32'd1);
    @(negedge clock); #2 reset = 1'b0;
    #1 check_idle_outputs("rst async");
    repeat (2) @(posedge clock);
    #1 check_idle_outputs("rst held");
    @(negedge clock); #2 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 check("rst mem 0x20 intact", dev_mem[8], 32'hCAFEBABE);
    run_vec("LW 0x20",  1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEBABE, 2'b00, 2, 0, 32'h0);

    // Back-to-back: valid held high across two loads.
    start_resp = resp_count;
    @(posedge clock); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clock); #1;
    t_first = acc_cyc;
    check("b2b ready T+1", 32'(req_ready), 32'd0);
    req_funct3 = 3'b101; req_addr = 32'h16;
    @(posedge clock); #1 check("b2b ready T+2", 32'(req_ready), 32'd0);
    @(posedge clock); #1 check("b2b ready T+3", 32'(req_ready), 32'd1);
    @(posedge clock); #1 req_valid = 1'b0;
    for (int i = 0; i < 12 && resp_count < start_resp + 2; i++) @(posedge clock);
    repeat (3) @(posedge clock);
    check("b2b resp pulses", 32'(resp_count - start_resp), 32'd2);
    check("b2b second accept", 32'(acc_cyc - t_first), 32'd3);
    check("b2b first resp cycle", 32'(prev_resp_cyc - t_first), 32'd2);
    check("b2b second resp cycle", 32'(last_resp_cyc - t_first), 32'd5);
    check("b2b first rdata", prev_rdata, 32'h8070ABFF);
    check("b2b second rdata", last_rdata, 32'h00001234);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the byte-addressed data memory. Takes one load/store request at a time from the CPU execute stage.
- Drives the memory's word-wide port (we / address / data_in, combinational data_out) using word-aligned addresses only.
- Performs byte/half extraction with sign/zero extension. Sub-word stores use read-modify-write because the memory has no byte enables.
- Reports misaligned, illegal or out-of-range requests without touching memory.

Parameters:
- MEM_BYTES, 128, size of the attached memory in bytes; a multiple of 4.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; equals (state==IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 out-of-range, 11 illegal funct3.
- mem_we  out  1  memory write enable.
- mem_address  out  32  always {addr[31:2],2'b00}.
- mem_data_in  out  32  word to write.
- mem_data_out  in  32  word read from mem_address, combinational.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (reset==0): state=IDLE; all request/response registers cleared.
  - resp_valid=0, resp_rdata=0, resp_err=00, mem_we=0, mem_address=0, mem_data_in=0.
  - req_ready=1 (combinational from state); req_valid is ignored while reset is low.
- Accept: in cycle T, with req_valid && req_ready, latch we, funct3, addr, wdata. Classify with this priority:
  - illegal funct3 (011, 110, 111, or a store with 100/101) → 11.
  - misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0) → 01.
  - out-of-range ({addr[31:2],2'b00} > MEM_BYTES-4) → 10.
- States:
  - IDLE → ERR (error), LOAD (load), WRITE (SW), RMW (SB/SH).
  - LOAD: drive mem_address; at the clock edge, capture the selected lane of mem_data_out (lane = addr[1:0] or addr[1]), extend it → RESP.
  - RMW: drive mem_address; at the clock edge, merge wdata[7:0] or wdata[15:0] into the captured word at the lane; hold the result in a merge register → WRITE.
  - WRITE: mem_we=1 for exactly this cycle; mem_data_in = merged word (SB/SH) or wdata (SW) → RESP.
  - ERR: no memory activity → RESP, with resp_err set.
  - RESP: resp_valid=1 for one cycle → IDLE.
- Latency, with resp_valid in the cycle shown:
  - error: T+2.
  - load: T+2.
  - SW: T+2, with mem_we in T+1.
  - SB/SH: T+3, with mem_we in T+2.
- Response hold: resp_rdata and resp_err are registered. They update on entering RESP and hold until the next RESP.
- Data extension: B sign-extends bit 7; H sign-extends bit 15; BU/HU zero-extend.
- Idle bus values: mem_we=0 in all states except WRITE. mem_address and mem_data_in hold their last values when idle.
- Back-to-back requests: req_ready=0 from T+1 through RESP. The next request is accepted in the cycle after RESP; no overlap.
- Request stability: request inputs are not sampled outside the accept cycle, so changes while busy are ignored.
- Reset mid-operation: mem_we falls asynchronously with reset, so no partial write occurs. The pending request is dropped and no response is produced.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum (IDLE, LOAD, RMW, WRITE, ERR, RESP);
  - error codes (ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_ILLEGAL).
- Sub-module lsu_align (combinational) performs lane extraction with extension and lane merge for stores. Reused by future cache logic.

Test Plan:
- Preload word 0x10 = 0x8070F0FF.
  - LB 0x10 → resp_rdata=0xFFFFFFFF at T+2.
  - LBU 0x13 → 0x00000080.
  - LH 0x12 → 0xFFFF8070.
  - LHU 0x10 → 0x0000F0FF.
- SB 0x11, wdata 0x123456AB → mem_address=0x10 in T+1 and T+2; mem_we=1 only in T+2 with mem_data_in=0x8070ABFF; then LW 0x10 → 0x8070ABFF.
- SW 0x14, 0xDEADBEEF → mem_we in T+1, resp at T+2. Then LW 0x14 → 0xDEADBEEF; LHU 0x16 → 0x0000DEAD; LB 0x14 → 0xFFFFFFEF.
- Error cases, each responding at T+2 with mem_we never asserted and resp_rdata=0:
  - LW 0x12 → resp_err=01.
  - SH 0x13 → 01.
  - LW 0x80 → 10.
  - funct3 011 → 11.
  - SB with funct3 100 → 11.
- Pull reset low during the WRITE cycle of SH 0x20 → mem_we drops immediately; memory 0x20 is unchanged; resp_valid=0; req_ready=1; all outputs read 0.
- Hold req_valid high with two loads queued → req_ready low T+1..T+2; second accepted T+3; its resp_valid at T+5; exactly two resp_valid pulses.
